ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to a PS/2 keyboard (for example `0xED` to set the LEDs, or `0xFF` to reset). It drives the open-drain PS/2 clock and data lines through active-high pull-low enables. It shares the PS/2 pins with the keyboard receiver, which must ignore the bus while `busy`=1. It reports completion, acknowledge failure, or timeout to the controlling logic.

---
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED to set
// the keyboard LEDs, 0xFF to reset it) over the shared open-drain PS/2 pins.
// The pins are never driven high: the block only asserts pull-low enables and
// relies on the bus pull-ups for the high level. The keyboard receiver that
// shares these pins must ignore the bus while busy=1.
//
// Ports
//   clk          system clock, all registers update on its rising edge
//   rst_n        asynchronous active-low reset; releases both lines at once
//   tx_data[7:0] command byte, captured when tx_start is accepted
//   tx_start     one-cycle request, accepted only while busy=0 in IDLE
//   busy         high from the cycle after acceptance until done pulses
//   done         one-cycle pulse at the end of every transaction
//   error[1:0]   result, valid with done and held until the next acceptance:
//                00 acknowledged, 01 no acknowledge, 10 timeout
//   ps2_clk_i    PS/2 clock pin level (asynchronous)
//   ps2_dat_i    PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 pulls the PS/2 clock line low
//   ps2_dat_oe   1 pulls the PS/2 data line low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic [1:0] error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One shared counter serves both the inhibit interval and the edge
    // timeout, so it is sized for the larger of the two and never wraps.
    localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_WAIT_CLK,
        S_SHIFT,
        S_ACK,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           state;
    logic [9:0]       shreg;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] timer;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic fe;
    logic timed_state;
    logic timed_out;

    // Two-flop synchronizers for the asynchronous pin levels, plus one extra
    // flop on the clock to detect its falling edge. They reset to 1 because
    // an idle PS/2 bus is pulled high, so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_i;
            dat_sync <= dat_meta;
        end
    end

    assign fe = clk_prev & ~clk_sync;

    // The edge timeout only runs while the device is expected to be clocking.
    // Any falling edge resets it, so it measures the gap between edges.
    assign timed_state = (state == S_WAIT_CLK) || (state == S_SHIFT) ||
                         (state == S_ACK)      || (state == S_RELEASE);
    assign timed_out   = timed_state && !fe && (timer == TIMEOUT_LAST);

    // Main transaction sequencer. All outputs are registered here so the pin
    // enables change cleanly on clock edges. The frame shift register holds
    // {stop, odd parity, data}; its LSB is the next bit to present, and a 0
    // bit is sent by pulling the data line low. A timeout overrides whatever
    // the current state would do and aborts straight to DONE with the lines
    // released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 2'b00;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timed_state) begin
                timer <= fe ? '0 : timer + 1'b1;
            end

            if (timed_out) begin
                state      <= S_DONE;
                timer      <= '0;
                error      <= 2'b10;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_start) begin
                            state      <= S_INHIBIT;
                            shreg      <= {1'b1, ~^tx_data, tx_data};
                            bit_cnt    <= '0;
                            timer      <= '0;
                            error      <= 2'b00;
                            busy       <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= 1'b0;
                        end
                    end

                    S_INHIBIT: begin
                        if (timer == INHIBIT_LAST) begin
                            state      <= S_START;
                            timer      <= '0;
                            ps2_dat_oe <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    S_START: begin
                        state      <= S_WAIT_CLK;
                        timer      <= '0;
                        ps2_clk_oe <= 1'b0;
                    end

                    S_WAIT_CLK: begin
                        if (fe) begin
                            state      <= S_SHIFT;
                            ps2_dat_oe <= ~shreg[0];
                            shreg      <= {1'b0, shreg[9:1]};
                        end
                    end

                    S_SHIFT: begin
                        if (fe) begin
                            if (bit_cnt == 4'd9) begin
                                state      <= S_ACK;
                                ps2_dat_oe <= 1'b0;
                            end else begin
                                ps2_dat_oe <= ~shreg[0];
                                shreg      <= {1'b0, shreg[9:1]};
                                bit_cnt    <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    S_ACK: begin
                        error <= dat_sync ? 2'b01 : 2'b00;
                        state <= S_RELEASE;
                    end

                    S_RELEASE: begin
                        if (clk_sync && dat_sync) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx. A behavioural keyboard model clocks each frame,
// samples the data line on every rising clock edge (plus the start bit before
// the first falling edge) and optionally pulls data low on the 11th falling
// edge as acknowledge. Expected frames come from a byte-level model and are
// queued when a command is issued; a monitor pops and compares on every done.
// A second instance with a short timeout exercises the no-clock case.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH       = 5000;
    localparam int HALF      = 50;
    localparam int TO_CYC    = 1000;
    localparam int TO_INH    = 20;
    localparam int DONE_WAIT = 20000;

    typedef struct {
        logic [10:0] bits;
        logic [1:0]  err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic [1:0] error;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       clk_line;
    logic       dat_line;

    logic       to_start;
    logic [7:0] to_data;
    logic       to_busy;
    logic       to_done;
    logic [1:0] to_error;
    logic       to_clk_oe;
    logic       to_dat_oe;
    logic       to_clk_line;
    logic       to_dat_line;

    logic        dev_clk_low;
    logic        dev_dat_low;
    logic        dev_active;
    logic        dev_ack_en;
    int          dev_edges;
    logic [10:0] cap;

    int   low_len;
    int   low_cnt;
    logic low_last_dat;
    logic low_dat_now;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    // Wired-AND open-drain bus with pull-ups
    assign clk_line    = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line    = ~(ps2_dat_oe | dev_dat_low);
    assign to_clk_line = ~to_clk_oe;
    assign to_dat_line = ~to_dat_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(750000)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    ps2_host_tx #(.INHIBIT_CYC(TO_INH), .TIMEOUT_CYC(TO_CYC)) u_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (to_data),
        .tx_start   (to_start),
        .busy       (to_busy),
        .done       (to_done),
        .error      (to_error),
        .ps2_clk_i  (to_clk_line),
        .ps2_dat_i  (to_dat_line),
        .ps2_clk_oe (to_clk_oe),
        .ps2_dat_oe (to_dat_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Comparison helper: every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-level frame model: start 0, data LSB first, odd parity, stop 1
    function automatic exp_t frameModel(input logic [7:0] d, input logic ack);
        exp_t e;
        int   ones;
        ones    = $countones(d);
        e.bits  = '0;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e.bits[i + 1] = ((d >> i) & 8'd1) != 8'd0;
        end
        e.bits[9]  = (ones % 2 == 0);
        e.bits[10] = 1'b1;
        e.err      = ack ? 2'b00 : 2'b01;
        return e;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic ack);
        int k;
        @(negedge clk);
        k = 0;
        while (busy && k < DONE_WAIT) begin
            @(negedge clk);
            k++;
        end
        dev_ack_en = ack;
        tx_data    = d;
        tx_start   = 1'b1;
        sb.push_back(frameModel(d, ack));
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic waitDone();
        int k;
        k = 0;
        while (done !== 1'b1 && k < DONE_WAIT) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_seen", 32'(done), 1);
    endtask

    // Keyboard model: reacts to the host request-to-send (clock released,
    // data low), then generates 11 clock pulses with HALF-cycle phases.
    initial begin
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_active  = 1'b0;
        dev_edges   = 0;
        cap         = '1;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && clk_line && !dat_line && !dev_active) begin
                dev_active = 1'b1;
                dev_edges  = 0;
                cap        = '1;
                repeat (20) @(negedge clk);
                cap[0] = dat_line;
                for (int n = 1; n <= 11; n++) begin
                    dev_clk_low = 1'b1;
                    dev_edges   = n;
                    if (n == 11 && dev_ack_en) dev_dat_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (n <= 10) cap[n] = dat_line;
                    repeat (HALF) @(negedge clk);
                end
                dev_dat_low = 1'b0;
                dev_active  = 1'b0;
            end
        end
    end

    // Measures each host clock-inhibit pulse and whether data was already
    // pulled low on its final cycle.
    initial begin
        low_len      = 0;
        low_cnt      = 0;
        low_last_dat = 1'b0;
        forever begin
            @(negedge clk);
            low_dat_now = ps2_dat_oe;
            if (ps2_clk_oe === 1'b1) begin
                low_cnt++;
                low_last_dat = low_dat_now;
            end else if (low_cnt > 0) begin
                low_len = low_cnt;
                low_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: each done must match the oldest queued frame
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                checkOutput("done_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("error_code", 32'(error), 32'(e.err));
                    checkOutput("frame_bits", 32'(cap), 32'(e.bits));
                    checkOutput("oe_at_done", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
                    checkOutput("inhibit_len", 32'(low_len), INH + 1);
                    checkOutput("start_overlap", 32'(low_last_dat), 1);
                    @(negedge clk);
                    checkOutput("done_single", 32'(done), 0);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         k;
        logic [7:0] d;
        logic       ack;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        to_start    = 1'b0;
        to_data     = 8'h00;
        dev_ack_en  = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy",  32'(busy), 0);
        checkOutput("reset_done",  32'(done), 0);
        checkOutput("reset_error", 32'(error), 0);
        checkOutput("reset_oe",    32'({ps2_clk_oe, ps2_dat_oe}), 0);
        checkOutput("reset_to_oe", 32'({to_clk_oe, to_dat_oe, to_busy}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] timeout case: device never clocks");
        to_data  = 8'hF4;
        to_start = 1'b1;
        @(negedge clk);
        to_start = 1'b0;
        k = 0;
        while (!(to_clk_oe == 1'b0 && to_dat_oe == 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("to_wait_clk_entry", 32'(k < 200), 1);
        k = 0;
        while (to_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("to_latency", 32'(k), TO_CYC);
        checkOutput("to_error",   32'(to_error), 2);
        checkOutput("to_oe",      32'({to_clk_oe, to_dat_oe}), 0);

        $display("[TB] directed frames");
        applyStimulus(8'hED, 1'b1); waitDone();
        applyStimulus(8'h00, 1'b1); waitDone();
        applyStimulus(8'hFF, 1'b1); waitDone();
        applyStimulus(8'hF4, 1'b0); waitDone();

        $display("[TB] tx_start while busy is ignored");
        applyStimulus(8'h5A, 1'b1);
        k = 0;
        while (dev_edges < 3 && k < DONE_WAIT) begin
            @(negedge clk);
            k++;
        end
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        waitDone();
        repeat (20) @(negedge clk);
        checkOutput("busy_after_ignored", 32'(busy), 0);

        $display("[TB] reset during data bit 4");
        applyStimulus(8'h2C, 1'b1);
        k = 0;
        while (dev_edges < 5 && k < DONE_WAIT) begin
            @(negedge clk);
            k++;
        end
        checkOutput("dev_edges_reached", 32'(dev_edges >= 5), 1);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_oe",    32'({ps2_clk_oe, ps2_dat_oe}), 0);
        checkOutput("async_busy",  32'(busy), 0);
        checkOutput("async_error", 32'(error), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (dev_active && k < DONE_WAIT) begin
            @(negedge clk);
            k++;
        end
        checkOutput("idle_after_reset", 32'({busy, done}), 0);
        applyStimulus(8'hFF, 1'b1); waitDone();

        $display("[TB] randomized frames");
        for (int i = 0; i < 3; i++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            applyStimulus(d, ack);
            waitDone();
        end

        // On the DONE cycle a request must be ignored; the next IDLE
        // cycle must accept a request.
        $display("[TB] back-to-back request after done");
        d = 8'($urandom_range(0, 255));
        tx_data  = ~d;
        tx_start = 1'b1;
        @(negedge clk);
        dev_ack_en = 1'b1;
        tx_data    = d;
        sb.push_back(frameModel(d, 1'b1));
        @(negedge clk);
        tx_start = 1'b0;
        waitDone();

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
